// File: rtl/flip_idx_serializer_pkg.sv
// flip_filter_pkg: shared types and width helpers for the flip-index serializer.
//   flip_ser_state_e : serializer FSM state (IDLE waits for a mask, DRAIN emits indices)
//   idx_width()      : bits needed to hold a spin index (at least 1)
//   cnt_width()      : bits needed to count 0..n beats
package flip_filter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } flip_ser_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flip_idx_serializer_lsb_picker.sv
// flip_lsb_picker: combinational priority pick over a request mask.
//   mask   in  NUM_REQ  candidate bits
//   grant  out NUM_REQ  one-hot of the winning bit (all zero when mask is empty)
//   idx    out IW       index of the winning bit (0 when mask is empty)
//   onehot out 1        mask has exactly one bit set
// LSB_PRIORITY=1 picks the lowest set bit; 0 picks the highest by bit-reversing
// the mask, doing the same lowest-first search, and mapping the result back.
module flip_lsb_picker #(
  parameter int NUM_REQ      = 256,
  parameter int LSB_PRIORITY = 1,
  parameter int IW           = 8
) (
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               onehot
);

  logic [NUM_REQ-1:0] ord_s;
  logic [NUM_REQ-1:0] grant_ord_s;
  logic [IW-1:0]      pos_s;
  logic               found_s;

  // Lowest-first search in "ordered" space, then map grant/index back to mask space.
  always_comb begin
    ord_s       = '0;
    grant_ord_s = '0;
    pos_s       = '0;
    found_s     = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (LSB_PRIORITY != 0) begin
        ord_s[i] = mask[i];
      end else begin
        ord_s[i] = mask[NUM_REQ-1-i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ord_s[i] && !found_s) begin
        found_s        = 1'b1;
        pos_s          = IW'(i);
        grant_ord_s[i] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (LSB_PRIORITY != 0) begin
        grant[i] = grant_ord_s[i];
      end else begin
        grant[i] = grant_ord_s[NUM_REQ-1-i];
      end
    end
    if (!found_s) begin
      idx = '0;
    end else if (LSB_PRIORITY != 0) begin
      idx = pos_s;
    end else begin
      idx = IW'(NUM_REQ - 1) - pos_s;
    end
  end

  // x & (x-1) clears the lowest set bit; zero result with non-zero x means exactly one bit.
  assign onehot = (mask != '0) && ((mask & (mask - NUM_REQ'(1))) == '0);

endmodule

// File: rtl/flip_idx_serializer.sv
// flip_idx_serializer: latches one flip mask and drains it one spin index per
// accepted beat in priority order, until the mask is empty or the per-mask flip
// budget is used up.
//   clk_i, rst_ni          clock; synchronous active-low reset
//   flush_i                abort current mask (no done pulse)
//   mask_valid_i/_ready_o  mask handshake (ready only in IDLE and not flushing)
//   mask_i                 flip mask, bit i = spin i wants to flip
//   idx_valid_o/_ready_i   index handshake; idx_o/last_o stable while stalled
//   idx_o, last_o          spin index and final-beat marker
//   done_o                 one-cycle pulse after a mask is finished
//   flip_cnt_o             beats accepted for the current/last mask
module flip_idx_serializer
  import flip_filter_pkg::*;
#(
  parameter int NUM_REQ      = 256,
  parameter int LSB_PRIORITY = 1,
  parameter int MAX_FLIPS    = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         mask_valid_i,
  output logic                         mask_ready_o,
  input  logic [NUM_REQ-1:0]           mask_i,
  output logic                         idx_valid_o,
  input  logic                         idx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]   idx_o,
  output logic                         last_o,
  output logic                         done_o,
  output logic [$clog2(NUM_REQ+1)-1:0] flip_cnt_o
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(NUM_REQ);

  flip_ser_state_e    state_r;
  logic [NUM_REQ-1:0] mask_r;
  logic [CW-1:0]      cnt_r;
  logic               done_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [IW-1:0]      pick_idx_s;
  logic               onehot_s;
  logic               budget_last_s;
  logic               beat_s;

  flip_lsb_picker #(
    .NUM_REQ      (NUM_REQ),
    .LSB_PRIORITY (LSB_PRIORITY),
    .IW           (IW)
  ) u_picker (
    .mask   (mask_r),
    .grant  (grant_s),
    .idx    (pick_idx_s),
    .onehot (onehot_s)
  );

  // A budget larger than the mask can never be reached, so it acts as unlimited.
  assign budget_last_s = (MAX_FLIPS != 0) && (int'(cnt_r) == MAX_FLIPS - 1);

  assign mask_ready_o = (state_r == IDLE) && !flush_i;
  assign idx_valid_o  = (state_r == DRAIN);
  assign last_o       = (state_r == DRAIN) && (onehot_s || budget_last_s);
  // mask_r is cleared whenever DRAIN is left, so idx_o reads 0 in IDLE.
  assign idx_o        = pick_idx_s;
  assign done_o       = done_r;
  assign flip_cnt_o   = cnt_r;
  assign beat_s       = idx_valid_o && idx_ready_i;

  // FSM, mask register, beat counter and done pulse; reset beats flush beats normal operation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      mask_r  <= '0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else if (flush_i) begin
      state_r <= IDLE;
      mask_r  <= '0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mask_valid_i) begin
            mask_r <= mask_i;
            cnt_r  <= '0;
            if (mask_i == '0) begin
              done_r <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat_s) begin
            cnt_r <= cnt_r + CW'(1);
            if (last_o) begin
              // Budget case may leave bits set; they are dropped here.
              state_r <= IDLE;
              mask_r  <= '0;
              done_r  <= 1'b1;
            end else begin
              mask_r <= mask_r & ~grant_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          mask_r  <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flip_idx_serializer.sv
module tb_flip_idx_serializer;

  logic       clk = 1'b0;
  logic       rst_n, flush, mv, rdy;
  logic [7:0] mask;

  logic       l_mrdy, l_vld, l_last, l_done;
  logic [2:0] l_idx;
  logic [3:0] l_cnt;
  logic       m_mrdy, m_vld, m_last, m_done;
  logic [2:0] m_idx;
  logic [3:0] m_cnt;
  logic       b_mrdy, b_vld, b_last, b_done;
  logic [2:0] b_idx;
  logic [3:0] b_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flip_idx_serializer #(.NUM_REQ(8), .LSB_PRIORITY(1), .MAX_FLIPS(0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_valid_i(mv), .mask_ready_o(l_mrdy),
    .mask_i(mask), .idx_valid_o(l_vld), .idx_ready_i(rdy), .idx_o(l_idx), .last_o(l_last),
    .done_o(l_done), .flip_cnt_o(l_cnt));

  flip_idx_serializer #(.NUM_REQ(8), .LSB_PRIORITY(0), .MAX_FLIPS(0)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_valid_i(mv), .mask_ready_o(m_mrdy),
    .mask_i(mask), .idx_valid_o(m_vld), .idx_ready_i(rdy), .idx_o(m_idx), .last_o(m_last),
    .done_o(m_done), .flip_cnt_o(m_cnt));

  flip_idx_serializer #(.NUM_REQ(8), .LSB_PRIORITY(1), .MAX_FLIPS(2)) u_bud (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_valid_i(mv), .mask_ready_o(b_mrdy),
    .mask_i(mask), .idx_valid_o(b_vld), .idx_ready_i(rdy), .idx_o(b_idx), .last_o(b_last),
    .done_o(b_done), .flip_cnt_o(b_cnt));

  typedef struct {
    logic       rst_n, flush, mv;
    logic [7:0] mask;
    logic       rdy;
    logic       e_mrdy, e_vld;
    logic [2:0] e_idx;
    logic       e_last, e_done;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic f, logic v, logic [7:0] m, logic rd,
                              logic er, logic ev, logic [2:0] ei, logic el, logic ed,
                              logic [3:0] ec);
    vec_t t;
    t.rst_n = r; t.flush = f; t.mv = v; t.mask = m; t.rdy = rd;
    t.e_mrdy = er; t.e_vld = ev; t.e_idx = ei; t.e_last = el; t.e_done = ed; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [7:0] m,
                       input logic rd);
    rst_n = r; flush = f; mv = v; mask = m; rdy = rd;
  endtask

  initial begin
    // Inputs and expected outputs seen during the same cycle (before its rising edge).
    tbl[0]  = mk(1, 0, 1, 8'hA6, 1, 1, 0, 0, 0, 0, 0);  // accept 1010_0110
    tbl[1]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 2, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 5, 0, 0, 2);
    tbl[4]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 7, 1, 0, 3);
    tbl[5]  = mk(1, 0, 1, 8'h00, 1, 1, 0, 0, 0, 1, 4);  // done; accept empty mask
    tbl[6]  = mk(1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0);  // empty mask -> done, cnt 0
    tbl[7]  = mk(1, 0, 1, 8'h18, 1, 1, 0, 0, 0, 0, 0);  // accept bits 3,4
    tbl[8]  = mk(1, 0, 0, 8'h00, 1, 0, 1, 3, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 4, 1, 0, 1);  // stall
    tbl[10] = mk(1, 0, 0, 8'h00, 0, 0, 1, 4, 1, 0, 1);  // stall
    tbl[11] = mk(1, 0, 0, 8'h00, 1, 0, 1, 4, 1, 0, 1);
    tbl[12] = mk(1, 0, 1, 8'hFF, 1, 1, 0, 0, 0, 1, 2);  // new mask in done cycle
    tbl[13] = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 1);
    tbl[15] = mk(1, 1, 1, 8'h01, 1, 0, 1, 2, 0, 0, 2);  // flush; mask not taken
    tbl[16] = mk(1, 0, 1, 8'h30, 1, 1, 0, 0, 0, 0, 0);  // idle, no done; accept 0x30
    tbl[17] = mk(0, 0, 0, 8'h00, 1, 0, 1, 4, 0, 0, 0);  // reset mid-drain
    tbl[18] = mk(1, 0, 1, 8'h81, 1, 1, 0, 0, 0, 0, 0);  // reset values; accept 0x81
    tbl[19] = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 8'h00, 1, 0, 1, 7, 1, 0, 1);
    tbl[21] = mk(1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 2);
    tbl[22] = mk(1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 2);

    // Reset and check reset state.
    drive(0, 0, 0, 8'h00, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 8'h00, 1);
    #1;
    chk("rst mask_ready", l_mrdy, 1);
    chk("rst idx_valid", l_vld, 0);
    chk("rst idx", l_idx, 0);
    chk("rst last", l_last, 0);
    chk("rst done", l_done, 0);
    chk("rst cnt", l_cnt, 0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].flush, tbl[i].mv, tbl[i].mask, tbl[i].rdy);
      #1;
      chk($sformatf("r%0d mask_ready", i), l_mrdy, tbl[i].e_mrdy);
      chk($sformatf("r%0d idx_valid", i), l_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("r%0d idx", i), l_idx, tbl[i].e_idx);
      else              chk($sformatf("r%0d idx", i), l_idx, 0);
      chk($sformatf("r%0d last", i), l_last, tbl[i].e_last);
      chk($sformatf("r%0d done", i), l_done, tbl[i].e_done);
      chk($sformatf("r%0d cnt", i), l_cnt, tbl[i].e_cnt);
    end

    // MSB-first priority: 1010_0110 -> 7,5,2,1.
    @(negedge clk); drive(0, 0, 0, 8'h00, 1);
    @(negedge clk); drive(1, 0, 1, 8'hA6, 1);
    #1; chk("msb accept ready", m_mrdy, 1);
    begin
      logic [2:0] exp_m [4];
      exp_m[0] = 3'd7; exp_m[1] = 3'd5; exp_m[2] = 3'd2; exp_m[3] = 3'd1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); drive(1, 0, 0, 8'h00, 1);
        #1;
        chk($sformatf("msb b%0d valid", k), m_vld, 1);
        chk($sformatf("msb b%0d idx", k), m_idx, exp_m[k]);
        chk($sformatf("msb b%0d last", k), m_last, (k == 3) ? 1 : 0);
      end
    end
    @(negedge clk); #1;
    chk("msb done", m_done, 1);
    chk("msb cnt", m_cnt, 4);
    chk("msb valid after", m_vld, 0);

    // Budget of 2 on 8'hFF -> 0,1 then done with remaining bits dropped.
    @(negedge clk); drive(0, 0, 0, 8'h00, 1);
    @(negedge clk); drive(1, 0, 1, 8'hFF, 1);
    @(negedge clk); drive(1, 0, 0, 8'h00, 1);
    #1;
    chk("bud b0 valid", b_vld, 1);
    chk("bud b0 idx", b_idx, 0);
    chk("bud b0 last", b_last, 0);
    @(negedge clk); #1;
    chk("bud b1 idx", b_idx, 1);
    chk("bud b1 last", b_last, 1);
    @(negedge clk); #1;
    chk("bud done", b_done, 1);
    chk("bud cnt", b_cnt, 2);
    chk("bud valid after", b_vld, 0);
    chk("bud idx after", b_idx, 0);
    chk("bud mask_ready", b_mrdy, 1);
    @(negedge clk); #1;
    chk("bud done pulse end", b_done, 0);
    chk("bud stays idle", b_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
